// File: rtl/sipo.sv
// Serial-in / parallel-out receiver for an 11-bit frame:
// start (0), eight data bits LSB first, parity, stop (1).
// The line is sampled once per baud clock edge.
// Parity is passed through unchecked at index 9.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | line idle; a sampled 0 is taken as the start bit
// RECEIVE | storing frame bits 1..10; the stop bit decides accept/drop
module sipo (
    input  logic        baud_clk_rx,
    input  logic        rst,
    input  logic        serial_data_tx,
    output logic [10:0] parallel_data_rx,
    output logic        active_flag_rx,
    output logic        received_flag
);

    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd10;

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [10:0] shift_buf;

    // Frame capture FSM: all outputs are registered here.
    always_ff @(posedge baud_clk_rx or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            bit_cnt          <= 4'd0;
            shift_buf        <= 11'h000;
            parallel_data_rx <= 11'h000;
            active_flag_rx   <= 1'b0;
            received_flag    <= 1'b0;
        end else begin
            received_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (!serial_data_tx) begin
                        shift_buf[0]   <= 1'b0;
                        bit_cnt        <= 4'd1;
                        active_flag_rx <= 1'b1;
                        state          <= RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (bit_cnt == LAST_IDX) begin
                        // Stop bit: accept only a high stop, otherwise drop the frame.
                        shift_buf[10]  <= serial_data_tx;
                        bit_cnt        <= 4'd0;
                        active_flag_rx <= 1'b0;
                        state          <= IDLE;
                        if (serial_data_tx) begin
                            parallel_data_rx <= {1'b1, shift_buf[9:0]};
                            received_flag    <= 1'b1;
                        end
                    end else begin
                        // A 0 here is data; start detection only happens in IDLE.
                        shift_buf[bit_cnt] <= serial_data_tx;
                        bit_cnt            <= bit_cnt + 4'd1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bit_cnt        <= 4'd0;
                    active_flag_rx <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo.sv
// Self-checking bench for sipo: accepted frames are pushed to a
// scoreboard when driven and popped when received_flag pulses.
`timescale 1ns/1ps
module tb_sipo;

    logic        baud_clk_rx;
    logic        rst;
    logic        serial_data_tx;
    logic [10:0] parallel_data_rx;
    logic        active_flag_rx;
    logic        received_flag;

    int          n_cmp;
    int          n_err;
    int          n_pulse;
    int          cyc;
    logic [10:0] exp_q[$];
    int          pulse_cyc[$];
    logic [10:0] last_good;

    sipo dut (
        .baud_clk_rx      (baud_clk_rx),
        .rst              (rst),
        .serial_data_tx   (serial_data_tx),
        .parallel_data_rx (parallel_data_rx),
        .active_flag_rx   (active_flag_rx),
        .received_flag    (received_flag)
    );

    initial baud_clk_rx = 1'b0;
    always #5 baud_clk_rx = ~baud_clk_rx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] data, input logic par);
        return {1'b1, par, data, 1'b0};
    endfunction

    // Scoreboard consumer: every pulse must match the oldest expected frame.
    initial begin
        cyc = 0;
        forever begin
            @(posedge baud_clk_rx);
            cyc++;
            #1;
            if (rst && received_flag) begin
                n_pulse++;
                pulse_cyc.push_back(cyc);
                if (exp_q.size() == 0)
                    chk("unexpected_pulse", 1, 0);
                else
                    chk("frame", parallel_data_rx, exp_q.pop_front());
            end
        end
    end

    task automatic send_bit(input logic b, input logic exp_act, input logic exp_rcv);
        @(negedge baud_clk_rx);
        serial_data_tx = b;
        @(posedge baud_clk_rx);
        #1;
        chk("active", active_flag_rx, exp_act);
        chk("rcv_flag", received_flag, exp_rcv);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [10:0] f);
        logic valid;
        valid = f[10];
        if (valid) exp_q.push_back(f);
        for (int i = 0; i < 11; i++)
            send_bit(f[i], (i < 10), (i == 10) && valid);
        if (valid) last_good = f;
        chk("hold", parallel_data_rx, last_good);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d;
        n_cmp = 0; n_err = 0; n_pulse = 0;
        last_good = 11'h000;
        rst = 1'b0;
        serial_data_tx = 1'b0;

        // Reset state, with a start-looking line held low.
        repeat (2) @(posedge baud_clk_rx);
        #1;
        chk("rst_data", parallel_data_rx, 11'h000);
        chk("rst_active", active_flag_rx, 1'b0);
        chk("rst_rcv", received_flag, 1'b0);
        serial_data_tx = 1'b1;
        #1 rst = 1'b1;

        // Idle line for 20 edges.
        idle(20);
        chk("idle_data", parallel_data_rx, 11'h000);

        // All-ones frame.
        send_frame(11'h7FE);
        chk("frame1_val", parallel_data_rx, 11'h7FE);

        // Parity 0 after two idle bits.
        idle(2);
        send_frame(11'h5FE);
        chk("frame2_val", parallel_data_rx, 11'h5FE);

        // Framing error: 0x55 data, parity 0, stop 0 -> dropped.
        send_frame(11'h0AA);
        chk("ferr_hold", parallel_data_rx, 11'h5FE);
        idle(1);

        // Back-to-back frames without an idle gap.
        send_frame(mk_frame(8'hA5, 1'b1));
        send_frame(mk_frame(8'h3C, 1'b0));
        if (pulse_cyc.size() >= 2) begin
            d = pulse_cyc[pulse_cyc.size()-1] - pulse_cyc[pulse_cyc.size()-2];
            chk("b2b_gap", d, 11);
        end else begin
            chk("b2b_pulses", pulse_cyc.size(), 2);
        end
        idle(2);

        // Reset asserted at bit 5 of a frame.
        send_bit(1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) send_bit(i[0], 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_data", parallel_data_rx, 11'h000);
        chk("mid_rst_active", active_flag_rx, 1'b0);
        chk("mid_rst_rcv", received_flag, 1'b0);
        last_good = 11'h000;
        repeat (2) @(posedge baud_clk_rx);
        #2 rst = 1'b1;
        // First edge after release samples the start bit.
        send_frame(mk_frame(8'h96, 1'b0));
        idle(2);

        chk("pulse_count", n_pulse, 5);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sipo.md
SIPO -- requirements
Module: sipo

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the reset is asynchronous and active-low, and the ports are named baud_clk_rx and rst.
REQ-002 baud_clk_rx  input  1  receive baud clock, one rising edge per serial bit period; all sampling and state changes occur on the rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 serial_data_tx  input  1  serial line, idle high.
REQ-005 parallel_data_rx  output  11  last accepted frame, registered.
REQ-006 active_flag_rx  output  1  high while a frame is being received.
REQ-007 received_flag  output  1  one-cycle pulse when a frame is accepted.

Function
REQ-008 The frame SHALL be 11 bits, in line order: start (0), 8 data bits, parity, stop (1).
REQ-009 The block SHALL sample serial_data_tx once per rising edge, with no oversampling.
REQ-010 The state machine SHALL have exactly two states, IDLE and RECEIVE.
REQ-011 IDLE transition: a sampled 0 SHALL be taken as the start bit and stored as frame bit 0, set the bit counter to 1, assert active_flag_rx and move to RECEIVE.
REQ-012 IDLE hold: a sampled 1 SHALL leave the block in IDLE with active_flag_rx low.
REQ-013 RECEIVE: each edge SHALL store the sampled bit at frame index = bit counter and increment the counter.
REQ-014 Bit placement: first-received bit SHALL be at index 0 and the stop bit at index 10.
REQ-015 On the edge that samples index 10 (the stop bit, 10 edges after the start-bit edge) with a sampled value of 1:
  - parallel_data_rx SHALL load the complete 11-bit frame;
  - received_flag SHALL be high for exactly that one cycle;
  - active_flag_rx SHALL go low;
  - the state SHALL return to IDLE.
REQ-016 Framing error: if the sampled stop bit is 0, the frame SHALL be discarded: parallel_data_rx unchanged, no received_flag pulse, active_flag_rx low, return to IDLE.
REQ-017 Parity: the parity bit SHALL be passed through at index 9 unchecked; parity evaluation is done downstream.
REQ-018 parallel_data_rx SHALL hold its value until the next accepted frame.
REQ-019 Back-to-back frames: a start bit sampled on the edge immediately after a stop-bit edge SHALL begin a new frame with no idle gap required.
REQ-020 Start-bit qualification: a 0 sampled while in RECEIVE SHALL be treated as data, never as a new start bit.
REQ-021 The bit counter SHALL be 4 bits and SHALL never exceed 10.

Reset
REQ-022 While rst is low, all of the following SHALL hold:
  - parallel_data_rx = 11'h000;
  - active_flag_rx = 0 and received_flag = 0;
  - state = IDLE and bit counter = 0;
  - the internal shift buffer is cleared.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately: no received_flag pulse, and the next frame is received correctly after release.
REQ-024 After rst is released, the first rising edge SHALL already be able to sample a start bit.

Verification
REQ-025 Idle line: rst high, line held 1 for 20 edges -> active_flag_rx = 0, received_flag never pulses, parallel_data_rx = 11'h000.
REQ-026 Frame 0,1,1,1,1,1,1,1,1,1,1 -> active_flag_rx high for 10 cycles, received_flag pulses once on the 11th edge, parallel_data_rx = 11'h7FE.
REQ-027 Frame 0,1,1,1,1,1,1,1,1,0,1 sent after two idle bits -> parallel_data_rx = 11'h5FE with a single received_flag pulse.
REQ-028 Frame 0,0x55 LSB-first (1,0,1,0,1,0,1,0),0,0 (stop = 0) -> no received_flag pulse, parallel_data_rx retains its previous value, and the block returns to IDLE.
REQ-029 Two back-to-back frames with no idle gap -> two received_flag pulses 11 cycles apart, each showing the correct frame.
REQ-030 rst pulsed low at bit 5 of a frame -> outputs clear at once, no received_flag pulse; a following valid frame is received correctly.
